// File: rtl/regs.sv
// Integer register file: 32x32, two bypassed read ports, hardwired x0,
// post-reset clear sweep and a req/ack debug port.
module regs #(
  parameter int REG_NUM = 32,
  parameter int ADDR_W  = 5,
  parameter int DATA_W  = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] reg1_raddr_i,
  output logic [DATA_W-1:0] reg1_rdata_o,
  input  logic [ADDR_W-1:0] reg2_raddr_i,
  output logic [DATA_W-1:0] reg2_rdata_o,
  input  logic [ADDR_W-1:0] reg_waddr_i,
  input  logic [DATA_W-1:0] reg_wdata_i,
  input  logic              reg_wen_i,
  output logic              init_busy_o,
  input  logic              dbg_req_i,
  input  logic              dbg_we_i,
  input  logic [ADDR_W-1:0] dbg_addr_i,
  input  logic [DATA_W-1:0] dbg_wdata_i,
  output logic              dbg_ack_o,
  output logic [DATA_W-1:0] dbg_rdata_o
);

  typedef enum logic [1:0] {
    S_INIT,
    S_IDLE,
    S_ACK
  } state_t;

  state_t              r_state;
  logic [ADDR_W-1:0]   r_cnt;
  logic                r_ack;
  logic [DATA_W-1:0]   r_rdata;
  logic [DATA_W-1:0]   r_regs [REG_NUM];

  logic              w_init;
  logic              w_byp1;
  logic              w_byp2;
  logic              w_bypd;
  logic              w_dbg_wr;
  logic [DATA_W-1:0] w_dbg_rd;

  assign w_init = (r_state == S_INIT);
  assign w_byp1 = reg_wen_i && (reg_waddr_i == reg1_raddr_i) && !w_init;
  assign w_byp2 = reg_wen_i && (reg_waddr_i == reg2_raddr_i) && !w_init;
  assign w_bypd = reg_wen_i && (reg_waddr_i == dbg_addr_i) && !w_init;

  assign reg1_rdata_o = (w_init || reg1_raddr_i == '0) ? '0 :
                        w_byp1 ? reg_wdata_i : r_regs[reg1_raddr_i];
  assign reg2_rdata_o = (w_init || reg2_raddr_i == '0) ? '0 :
                        w_byp2 ? reg_wdata_i : r_regs[reg2_raddr_i];
  assign w_dbg_rd     = (dbg_addr_i == '0) ? '0 :
                        w_bypd ? reg_wdata_i : r_regs[dbg_addr_i];

  // execute owns the write port; debug writes only slip into idle cycles
  assign w_dbg_wr = (r_state == S_IDLE) && dbg_req_i && dbg_we_i &&
                    !reg_wen_i && (dbg_addr_i != '0);

  assign init_busy_o = w_init;
  assign dbg_ack_o   = r_ack;
  assign dbg_rdata_o = r_rdata;

  always_ff @(posedge clk) begin
    if (!rst) begin
      if (w_init)
        r_regs[r_cnt] <= '0;
      else if (reg_wen_i) begin
        if (reg_waddr_i != '0)
          r_regs[reg_waddr_i] <= reg_wdata_i;
      end else if (w_dbg_wr)
        r_regs[dbg_addr_i] <= dbg_wdata_i;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_INIT;
      r_cnt   <= ADDR_W'(1);
      r_ack   <= 1'b0;
      r_rdata <= '0;
    end else begin
      unique case (r_state)
        S_INIT: begin
          r_ack <= 1'b0;
          r_cnt <= r_cnt + ADDR_W'(1);
          if (r_cnt == ADDR_W'(REG_NUM - 1))
            r_state <= S_IDLE;
        end
        S_IDLE: begin
          r_ack <= 1'b0;
          if (dbg_req_i) begin
            if (!dbg_we_i) begin
              r_rdata <= w_dbg_rd;
              r_ack   <= 1'b1;
              r_state <= S_ACK;
            end else if (!reg_wen_i) begin
              r_ack   <= 1'b1;
              r_state <= S_ACK;
            end
          end
        end
        S_ACK: begin
          r_ack   <= 1'b0;
          r_state <= S_IDLE;
        end
        default: begin
          r_ack   <= 1'b0;
          r_state <= S_INIT;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_regs.sv
// Scoreboard bench for regs: stimulus queues expectations,
// a negedge monitor pops and compares them.
module tb_regs;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  reg1_raddr_i, reg2_raddr_i, reg_waddr_i, dbg_addr_i;
  logic [31:0] reg1_rdata_o, reg2_rdata_o, reg_wdata_i, dbg_wdata_i;
  logic [31:0] dbg_rdata_o;
  logic        reg_wen_i, init_busy_o, dbg_req_i, dbg_we_i, dbg_ack_o;

  regs dut (
    .clk(clk), .rst(rst),
    .reg1_raddr_i(reg1_raddr_i), .reg1_rdata_o(reg1_rdata_o),
    .reg2_raddr_i(reg2_raddr_i), .reg2_rdata_o(reg2_rdata_o),
    .reg_waddr_i(reg_waddr_i), .reg_wdata_i(reg_wdata_i),
    .reg_wen_i(reg_wen_i), .init_busy_o(init_busy_o),
    .dbg_req_i(dbg_req_i), .dbg_we_i(dbg_we_i),
    .dbg_addr_i(dbg_addr_i), .dbg_wdata_i(dbg_wdata_i),
    .dbg_ack_o(dbg_ack_o), .dbg_rdata_o(dbg_rdata_o)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct packed {
    logic [31:0] cyc;
    logic [2:0]  sig;
    logic [31:0] exp;
    logic [95:0] name;
  } chk_t;

  typedef struct packed {
    logic [31:0] cyc;
    logic        chkd;
    logic [31:0] exp;
    logic [95:0] name;
  } ack_t;

  chk_t chk_q[$];
  ack_t ack_q[$];
  int n_vec = 0;
  int n_bad = 0;

  // sig: 0 port1, 1 port2, 2 busy, 3 ack, 4 dbg rdata
  task automatic expect_sig(input int sig, input logic [31:0] v,
                            input logic [95:0] n);
    chk_t c;
    c.cyc = cyc; c.sig = 3'(sig); c.exp = v; c.name = n;
    chk_q.push_back(c);
  endtask

  task automatic expect_ack(input int at, input logic chkd,
                            input logic [31:0] v, input logic [95:0] n);
    ack_t a;
    a.cyc = at; a.chkd = chkd; a.exp = v; a.name = n;
    ack_q.push_back(a);
  endtask

  chk_t        mc;
  ack_t        ma;
  logic [31:0] act;
  logic        exp_a;

  always @(negedge clk) begin
    while (chk_q.size() > 0 && chk_q[0].cyc == cyc) begin
      mc = chk_q.pop_front();
      case (mc.sig)
        3'd0:    act = reg1_rdata_o;
        3'd1:    act = reg2_rdata_o;
        3'd2:    act = {31'd0, init_busy_o};
        3'd3:    act = {31'd0, dbg_ack_o};
        default: act = dbg_rdata_o;
      endcase
      n_vec++;
      if (act !== mc.exp) begin
        n_bad++;
        $display("FAIL %0s cyc=%0d got %h want %h", mc.name, cyc, act, mc.exp);
      end
    end
    if (cyc >= 2) begin
      exp_a = ack_q.size() > 0 && ack_q[0].cyc == cyc;
      if (dbg_ack_o !== 1'b0 || exp_a) begin
        n_vec++;
        if (dbg_ack_o !== exp_a) begin
          n_bad++;
          $display("FAIL ack_timing cyc=%0d got %b want %b", cyc, dbg_ack_o, exp_a);
        end else if (ack_q[0].chkd && dbg_rdata_o !== ack_q[0].exp) begin
          n_bad++;
          $display("FAIL %0s cyc=%0d got %h want %h", ack_q[0].name, cyc,
                   dbg_rdata_o, ack_q[0].exp);
        end
        if (exp_a) void'(ack_q.pop_front());
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic dbg_write(input logic [4:0] a, input logic [31:0] d);
    dbg_req_i = 1; dbg_we_i = 1; dbg_addr_i = a; dbg_wdata_i = d;
    expect_ack(cyc + 1, 1'b0, 32'h0, "dbg_wr_ack");
    step();
    dbg_req_i = 0;
    step();
  endtask

  task automatic dbg_read(input logic [4:0] a, input logic [31:0] d);
    dbg_req_i = 1; dbg_we_i = 0; dbg_addr_i = a;
    expect_ack(cyc + 1, 1'b1, d, "dbg_rd");
    step();
    dbg_req_i = 0;
    step();
  endtask

  // called in the first cycle with rst low
  task automatic sweep_check();
    reg1_raddr_i = 5; reg2_raddr_i = 7;
    for (int i = 0; i < 32; i++) begin
      expect_sig(2, (i < 31) ? 32'd1 : 32'd0, "init_busy");
      if (i == 0) begin
        expect_sig(3, 32'd0, "rst_ack");
        expect_sig(4, 32'd0, "rst_rdata");
      end
      if (i < 31) expect_sig(0, 32'd0, "init_rd0");
      reg_wen_i = (i == 3); reg_waddr_i = 7; reg_wdata_i = 32'h1;
      if (i == 3) expect_sig(1, 32'd0, "init_nobyp");
      step();
    end
    reg_wen_i = 0;
    expect_sig(0, 32'd0, "x5_cleared");
    expect_sig(1, 32'd0, "x7_dropped");
    step();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog cyc=%0d", cyc);
    $fatal(1);
  end

  initial begin
    rst = 1; reg1_raddr_i = 0; reg2_raddr_i = 0;
    reg_waddr_i = 0; reg_wdata_i = 0; reg_wen_i = 0;
    dbg_req_i = 0; dbg_we_i = 0; dbg_addr_i = 0; dbg_wdata_i = 0;
    step(); step();
    rst = 0;
    sweep_check();

    dbg_write(5, 32'h12345678);
    reg1_raddr_i = 5;
    expect_sig(0, 32'h12345678, "x5_preload");
    rst = 1;
    step();
    rst = 0;
    sweep_check();

    reg_wen_i = 1; reg_waddr_i = 3; reg_wdata_i = 32'hDEADBEEF;
    reg1_raddr_i = 3; reg2_raddr_i = 3;
    expect_sig(0, 32'hDEADBEEF, "byp_p1");
    expect_sig(1, 32'hDEADBEEF, "byp_p2");
    step();
    reg_wen_i = 0;
    expect_sig(0, 32'hDEADBEEF, "arr_p1");
    expect_sig(1, 32'hDEADBEEF, "arr_p2");
    step();
    reg_wen_i = 1; reg_waddr_i = 0; reg_wdata_i = 32'hFFFFFFFF;
    reg1_raddr_i = 0; reg2_raddr_i = 0;
    expect_sig(0, 32'h0, "x0_byp_p1");
    expect_sig(1, 32'h0, "x0_byp_p2");
    step();
    reg_wen_i = 0;
    expect_sig(0, 32'h0, "x0_next");
    step();

    reg_wen_i = 1; reg_waddr_i = 10; reg_wdata_i = 32'hA5A5A5A5;
    step();
    reg_wen_i = 0;
    dbg_read(10, 32'hA5A5A5A5);
    reg_wen_i = 1; reg_waddr_i = 10; reg_wdata_i = 32'h1;
    dbg_req_i = 1; dbg_we_i = 0; dbg_addr_i = 10;
    expect_ack(cyc + 1, 1'b1, 32'h1, "dbg_rd_byp");
    step();
    reg_wen_i = 0; dbg_req_i = 0;
    step();

    dbg_req_i = 1; dbg_we_i = 1; dbg_addr_i = 4; dbg_wdata_i = 32'h55;
    expect_ack(cyc + 4, 1'b0, 32'h0, "coll_ack");
    reg_wen_i = 1; reg_waddr_i = 9; reg_wdata_i = 32'h9;
    step(); step(); step();
    reg_wen_i = 0;
    step();
    dbg_req_i = 0;
    step();
    reg1_raddr_i = 4; reg2_raddr_i = 9;
    expect_sig(0, 32'h55, "coll_x4");
    expect_sig(1, 32'h9, "coll_x9");
    step();

    dbg_req_i = 1; dbg_we_i = 0; dbg_addr_i = 10;
    expect_ack(cyc + 1, 1'b1, 32'h1, "held_rd1");
    expect_ack(cyc + 3, 1'b1, 32'h1, "held_rd2");
    step(); step(); step(); step();
    dbg_req_i = 0;
    step();

    dbg_req_i = 1; dbg_we_i = 0; dbg_addr_i = 3;
    expect_ack(cyc + 1, 1'b1, 32'hDEADBEEF, "dbg_rd_x3");
    step();
    dbg_req_i = 0; rst = 1;
    step();
    rst = 0;
    sweep_check();
    step(); step();

    n_vec++;
    if (chk_q.size() != 0 || ack_q.size() != 0) begin
      n_bad++;
      $display("FAIL pending got %0d/%0d want 0/0", chk_q.size(), ack_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
